// File: rtl/pipe_cr_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipe_cr_adder_pkg
// Shared definitions for the pipelined carry-ripple adder:
//   - DEF_WIDTH / DEF_STAGES : default operand width and pipeline depth
//   - stage_t                : contents of one pipeline stage register
//   - signed_ovf()           : two's-complement overflow from sign bits
// -----------------------------------------------------------------------------
package pipe_cr_adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  // One stage register. Operand words travel with the transaction so every
  // stage only ever holds bits belonging to a single add. The sum word fills
  // from the bottom, one chunk per stage.
  typedef struct packed {
    logic                 valid;
    logic [DEF_WIDTH-1:0] sum;     // chunks 0..k are meaningful at stage k
    logic                 carry;   // carry out of the highest finished chunk
    logic [DEF_WIDTH-1:0] a_rem;   // operand a, still needed by later chunks
    logic [DEF_WIDTH-1:0] b_rem;   // effective operand b (inverted on subtract)
    logic                 a_sign;  // a[W-1]
    logic                 b_sign;  // b_eff[W-1]
  } stage_t;

  // Overflow when both addends share a sign and the result's sign differs.
  function automatic logic signed_ovf(input logic a_sign,
                                      input logic b_sign,
                                      input logic s_sign);
    return (a_sign == b_sign) && (s_sign != a_sign);
  endfunction

endpackage

// File: rtl/pipe_cr_adder_slice.sv
// -----------------------------------------------------------------------------
// cra_slice
// Combinational W-bit ripple-carry adder slice: {cout, sum} = a + b + cin.
// Ports:
//   a, b  : W-bit addends
//   cin   : carry in
//   sum   : W-bit sum
//   cout  : carry out of bit W-1
// -----------------------------------------------------------------------------
module cra_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves a latch.
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[W];

endmodule

// File: rtl/pipe_cr_adder.sv
// -----------------------------------------------------------------------------
// pipe_cr_adder
// STAGES-deep pipelined ripple-carry adder with valid/ready handshakes. Stage k
// adds operand chunk k with the carry registered by stage k-1 (stage 0 uses
// cin), so the carry chain per cycle is only CHUNK = WIDTH/STAGES bits long.
// The whole pipeline advances together; a stalled consumer freezes every stage.
//
// Optional feature: define PIPE_CR_ADDER_SUB_EN to add the `sub` port; sub=1
// computes a + ~b + 1 (cin ignored, cout=1 means no borrow). Without the macro
// the block is add-only and has no `sub` port.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : operand set valid
//   in_ready   : block accepts operands this cycle (= advance enable)
//   a, b, cin  : operands and carry in
//   sub        : subtract select (PIPE_CR_ADDER_SUB_EN only)
//   out_valid  : result valid
//   out_ready  : consumer accepts the result
//   sum, cout  : {cout, sum} = a + b_eff + cin_eff
//   overflow   : two's-complement signed overflow of the result
// -----------------------------------------------------------------------------
module pipe_cr_adder
  import pipe_cr_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_CR_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CHUNK = WIDTH / STAGES;

  // The stage register layout lives in the package and is sized by DEF_WIDTH,
  // so the operand width must match it and split evenly into chunks.
  if ((WIDTH != DEF_WIDTH) || ((WIDTH % STAGES) != 0) || (STAGES < 1)) begin : g_bad_cfg
    $error("pipe_cr_adder: WIDTH must equal DEF_WIDTH and be a multiple of STAGES");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // The last stage can take a new value whenever its current one is absent
  // or being consumed; since all stages move in lockstep this is the global
  // advance enable and also the input-side ready.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

`ifdef PIPE_CR_ADDER_SUB_EN
  // a - b = a + ~b + 1; the forced carry-in replaces cin when subtracting.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           src;   // what this stage consumes this cycle
    stage_t           nxt;   // src with chunk k of the sum filled in
    stage_t           q;     // this stage's register
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;

    if (k == 0) begin : g_head
      // Stage 0 builds its source straight from the ports; the incoming
      // carry slot holds the effective carry-in so every slice is uniform.
      always_comb begin
        src        = '0;
        src.valid  = in_valid;
        src.carry  = cin_eff;
        src.a_rem  = a;
        src.b_rem  = b_eff;
        src.a_sign = a[WIDTH-1];
        src.b_sign = b_eff[WIDTH-1];
      end
    end else begin : g_body
      assign src = g_stage[k-1].q;
    end

    cra_slice #(
      .W (CHUNK)
    ) u_slice (
      .a    (src.a_rem[k*CHUNK +: CHUNK]),
      .b    (src.b_rem[k*CHUNK +: CHUNK]),
      .cin  (src.carry),
      .sum  (slice_sum),
      .cout (slice_cout)
    );

    always_comb begin
      nxt                        = src;
      nxt.sum[k*CHUNK +: CHUNK]  = slice_sum;
      nxt.carry                  = slice_cout;
    end

    // Bubbles only clear the valid bit; data fields keep their last value so
    // the outputs never change while nothing valid is presented.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        // NOTE: the data fields are reset along with valid so sum/cout/overflow read 0, never X.
        q <= '0;
      end else if (adv) begin
        // NOTE: non-blocking assignment, so each stage samples its predecessor's pre-edge value.
        if (src.valid) begin
          q <= nxt;
        end else begin
          q.valid <= 1'b0;
        end
      end
    end
  end

  stage_t tail;
  assign tail = g_stage[STAGES-1].q;

  assign out_valid = tail.valid;
  assign sum       = tail.sum[WIDTH-1:0];
  assign cout      = tail.carry;
  assign overflow  = signed_ovf(tail.a_sign, tail.b_sign, tail.sum[WIDTH-1]);

  // The last stage's operand copies have no consumer.
  logic unused_tail_ops;
  assign unused_tail_ops = ^{tail.a_rem, tail.b_rem};

endmodule

// File: tb/tb_pipe_cr_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_cr_adder
// Directed testbench for pipe_cr_adder (WIDTH=32, STAGES=4). Covers reset
// state, carry propagation across all chunks, signed overflow, back-to-back
// streaming, back-pressure and mid-flight reset. Subtract vectors are included
// when PIPE_CR_ADDER_SUB_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipe_cr_adder;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef PIPE_CR_ADDER_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_cr_adder #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef PIPE_CR_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction: result must appear exactly S cycles later,
  // for exactly one cycle.
  task automatic run_single(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic tc, input logic [W-1:0] es, input logic ec,
                            input logic eo);
    out_ready = 1'b1;
    a         = ta;
    b         = tb_;
    cin       = tc;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check({tag, " early_valid"}, out_valid, 1'b0);
    tick();
    check({tag, " valid"}, out_valid, 1'b1);
    check({tag, " sum"}, sum, es);
    check({tag, " cout"}, cout, ec);
    check({tag, " ovf"}, overflow, eo);
    tick();
    check({tag, " single"}, out_valid, 1'b0);
  endtask

  // Stream n random adds. out_ready is dropped for cycles stall_lo..stall_hi;
  // with stall_lo > stall_hi there is no stall and the exact valid pattern
  // (results on n consecutive cycles starting at cycle S) is checked.
  task automatic stream(input string tag, input int n, input int stall_lo, input int stall_hi);
    logic [W+1:0] exp_q[$];
    logic [W+1:0] e;
    logic [W:0]   r;
    logic [W-1:0] ta, tb_, held;
    logic         tc, acc, eo;
    bit           pending, have_held, stall_mode;
    int           idx, rx;
    pending    = 0;
    have_held  = 0;
    stall_mode = (stall_lo <= stall_hi);
    idx        = 0;
    rx         = 0;
    ta = '0; tb_ = '0; tc = 1'b0; held = '0;
    for (int c = 0; c < 60 && rx < n; c++) begin
      out_ready = !(c >= stall_lo && c <= stall_hi);
      if (!pending && idx < n) begin
        ta      = $urandom;
        tb_     = $urandom;
        tc      = 1'($urandom_range(0, 1));
        pending = 1;
      end
      in_valid = pending;
      a        = ta;
      b        = tb_;
      cin      = tc;
      #1;
      if (!stall_mode) check({tag, " valid_pattern"}, out_valid, (c >= S && c < S + n));
      if (stall_mode && c >= stall_lo && c <= stall_hi) begin
        check({tag, " stall_valid"}, out_valid, 1'b1);
        check({tag, " stall_in_ready"}, in_ready, 1'b0);
        if (have_held) check({tag, " stall_sum_stable"}, sum, held);
        held      = sum;
        have_held = 1;
      end
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        check({tag, " sum"}, sum, e[W-1:0]);
        check({tag, " cout"}, cout, e[W]);
        check({tag, " ovf"}, overflow, e[W+1]);
        rx++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        r  = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
        eo = (ta[W-1] == tb_[W-1]) && (r[W-1] != ta[W-1]);
        exp_q.push_back({eo, r});
        pending = 0;
        idx++;
      end
    end
    check({tag, " result_count"}, rx, n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check({tag, " no_extra"}, out_valid, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
`ifdef PIPE_CR_ADDER_SUB_EN
    sub       = 1'b0;
`endif

    // Reset state
    tick();
    tick();
    check("rst out_valid", out_valid, 1'b0);
    check("rst sum", sum, 32'h0);
    check("rst cout", cout, 1'b0);
    check("rst ovf", overflow, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rst in_ready", in_ready, 1'b1);
    tick();
    check("post_rst in_ready", in_ready, 1'b1);

    // Directed single transactions
    run_single("carry_chain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_single("pos_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_single("neg_ovf",     32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    run_single("cin_only",    32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
    run_single("mixed",       32'h1234_5678, 32'h0FED_CBA9, 1'b1, 32'h2222_2222, 1'b0, 1'b0);
    run_single("all_ones",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);

`ifdef PIPE_CR_ADDER_SUB_EN
    sub = 1'b1;
    run_single("sub_neg",     32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_single("sub_cin_ign", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_single("sub_pos",     32'h0000_0007, 32'h0000_0005, 1'b0, 32'h0000_0002, 1'b1, 1'b0);
    run_single("sub_ovf",     32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    sub = 1'b0;
    run_single("sub_off",     32'h0000_0005, 32'h0000_0007, 1'b0, 32'h0000_000C, 1'b0, 1'b0);
`endif

    // Back-to-back streaming and back-pressure
    stream("b2b", 8, 1, 0);
    stream("bp", 6, 5, 7);

    // Reset with three transactions in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a        = $urandom;
      b        = $urandom;
      cin      = 1'b1;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    check("midrst out_valid", out_valid, 1'b0);
    check("midrst sum", sum, 32'h0);
    check("midrst cout", cout, 1'b0);
    rst_n = 1'b1;
    #1;
    check("midrst in_ready", in_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("midrst no_stale", out_valid, 1'b0);
    end

    // Pipeline still works after the mid-flight reset
    run_single("after_rst", 32'h0000_00FF, 32'h0000_0F01, 1'b0, 32'h0000_1000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_cr_adder.md
PIPE_CR_ADDER -- requirements
Module: pipe_cr_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4, giving the pipeline depth; WIDTH mod STAGES SHALL be 0 and CHUNK = WIDTH/STAGES.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port cin, input, 1 bit: the carry-in.
REQ-009 The block SHALL have port sub, input, 1 bit: subtract select; this port exists only with PIPE_CR_ADDER_SUB_EN.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-013 The block SHALL have port cout, output, 1 bit: the carry out of bit WIDTH-1.
REQ-014 The block SHALL have port overflow, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 A transfer SHALL occur on a rising edge when in_valid and in_ready are both 1.
REQ-016 A result SHALL be consumed on a rising edge when out_valid and out_ready are both 1.
REQ-017 Global advance enable adv SHALL be !out_valid || out_ready, and in_ready SHALL equal adv, combinationally.
REQ-018 When adv=1, every stage register SHALL load from its predecessor; when adv=0, all stage registers, including sum, cout and overflow, SHALL hold.
REQ-019 Stage k (0..STAGES-1) SHALL add operand bits [k*CHUNK +: CHUNK] using the carry registered by stage k-1 (stage 0 uses cin) and SHALL register CHUNK sum bits plus the carry.
REQ-020 Operand bits above chunk k SHALL be delay-registered alongside, so each stage register holds one transaction only.
REQ-021 Each stage SHALL carry a valid bit; bubbles (in_valid=0 while adv=1) SHALL propagate as valid=0.
REQ-022 Latency SHALL be exactly STAGES cycles from accept to out_valid when out_ready is held at 1.
REQ-023 Throughput SHALL be one result per cycle, and results SHALL leave in acceptance order.
REQ-024 sum and cout SHALL equal {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
REQ-025 overflow SHALL be (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]), computed from bits registered with the transaction; b_eff is b, or ~b when subtracting.
REQ-026 When out_valid=0, sum, cout and overflow SHALL be don't-care for the consumer, but SHALL hold their last value (no X).

Reset
REQ-027 While rst_n=0 at a rising edge, all stage valid bits, sum, cout and overflow SHALL clear to 0; out_valid SHALL read 0 in the following cycle.
REQ-028 Reset mid-flight SHALL discard every in-flight transaction and emit no partial result.
REQ-029 in_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-030 With PIPE_CR_ADDER_SUB_EN defined, sub=1 SHALL compute a + ~b + 1 (cin ignored), so cout=1 means no borrow; sub=0 SHALL behave as plain add.
REQ-031 Without PIPE_CR_ADDER_SUB_EN, the sub port and its inversion logic SHALL be absent, and behaviour SHALL be add-only.

Structure
REQ-032 Package pipe_cr_adder_pkg SHALL hold the WIDTH and STAGES defaults and a stage-register struct type {valid, sum part, carry, remaining operand bits, sign bits}.
REQ-033 One combinational sub-module, cra_slice (CHUNK-bit ripple-carry slice: a, b, cin -> sum, cout), SHALL be instantiated once per stage.

Verification
REQ-034 With WIDTH=32 and STAGES=4, the bench SHALL drive a=0xFFFFFFFF, b=0x1, cin=0 -> after 4 cycles, sum=0x0, cout=1, overflow=0 (carry crosses every stage).
REQ-035 The bench SHALL drive a=0x7FFFFFFF, b=0x1, cin=0 -> sum=0x80000000, cout=0, overflow=1.
REQ-036 The bench SHALL drive 8 back-to-back random operations with out_ready=1 -> 8 correct results on 8 consecutive cycles, in order, starting at cycle 4.
REQ-037 The bench SHALL hold out_ready=0 for 3 cycles while out_valid=1 -> in_ready=0 and sum stable; on release, no transaction is lost or duplicated.
REQ-038 The bench SHALL assert rst_n=0 for 1 cycle with 3 transactions in flight -> out_valid=0 the next cycle, and no stale result appears afterward.
REQ-039 With PIPE_CR_ADDER_SUB_EN defined, the bench SHALL drive a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, overflow=0.
